// File: rtl/gate_sweep_controller_if.sv
// Control/status bundle between a sweep harness and gate_sweep_controller.
//   start, abort       harness -> controller: begin / cancel a sweep
//   busy               controller is sequencing vectors
//   vec_idx            vector currently applied, {in0,in1}
//   result, fail_mask  captured gate output / mismatch per vector index
//   done, pass         one-cycle completion pulse / last sweep matched
interface gate_sweep_controller_if;
  logic       start;
  logic       abort;
  logic       busy;
  logic [1:0] vec_idx;
  logic [3:0] result;
  logic [3:0] fail_mask;
  logic       done;
  logic       pass;

  modport master (output start, abort,
                  input  busy, vec_idx, result, fail_mask, done, pass);
  modport slave  (input  start, abort,
                  output busy, vec_idx, result, fail_mask, done, pass);
endinterface

// File: rtl/gate_sweep_controller.sv
// Walks a 2-input gate through {in0,in1} = 00,01,10,11. Each vector is held
// SETTLE_CYCLES cycles, then the gate output is sampled for one cycle and
// compared against EXPECT[{in0,in1}].
//   clk, rst_n  clock, asynchronous active-low reset
//   ctl         control/status bundle (slave side)
//   dut_out     output of the gate under test
//   in0, in1    registered gate inputs; always equal vec_idx while busy
module gate_sweep_controller #(
  parameter int unsigned SETTLE_CYCLES = 4,       // 1..255
  parameter logic [3:0]  EXPECT        = 4'b0000  // bit index = {in0,in1}
) (
  input  logic                    clk,
  input  logic                    rst_n,
  gate_sweep_controller_if.slave  ctl,
  input  logic                    dut_out,
  output logic                    in0,
  output logic                    in1
);

  typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [7:0] cnt;
  logic [1:0] vec_q;
  logic [3:0] result_q;
  logic [3:0] fail_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [1:0] vec_nxt;

  assign vec_nxt = vec_q + 2'd1;

  assign ctl.busy      = busy_q;
  assign ctl.vec_idx   = vec_q;
  assign ctl.result    = result_q;
  assign ctl.fail_mask = fail_q;
  assign ctl.done      = done_q;
  assign ctl.pass      = pass_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      vec_q    <= '0;
      in0      <= 1'b0;
      in1      <= 1'b0;
      result_q <= '0;
      fail_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (ctl.abort && state != IDLE) begin
        // Partial result/fail_mask are left visible for debug.
        state  <= IDLE;
        vec_q  <= '0;
        in0    <= 1'b0;
        in1    <= 1'b0;
        busy_q <= 1'b0;
        pass_q <= 1'b0;
      end else begin
        unique case (state)
          IDLE: begin
            if (ctl.start && !ctl.abort) begin
              state    <= SETTLE;
              cnt      <= CNT_LOAD;
              vec_q    <= '0;
              in0      <= 1'b0;
              in1      <= 1'b0;
              result_q <= '0;
              fail_q   <= '0;
              pass_q   <= 1'b0;
              busy_q   <= 1'b1;
            end
          end
          SETTLE: begin
            if (cnt == 8'd0) state <= SAMPLE;
            else             cnt   <= cnt - 8'd1;
          end
          SAMPLE: begin
            result_q[vec_q] <= dut_out;
            fail_q[vec_q]   <= dut_out ^ EXPECT[vec_q];
            if (vec_q == 2'd3) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              // Gate inputs move only after the sample has been taken.
              vec_q      <= vec_nxt;
              {in0, in1} <= vec_nxt;
              cnt        <= CNT_LOAD;
              state      <= SETTLE;
            end
          end
          DONE: begin
            // fail_mask already holds the last vector's compare here.
            pass_q <= (fail_q == 4'd0);
            busy_q <= 1'b0;
            state  <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gate_sweep_controller.sv
// Four controller instances:
//   0: AND gate, EXPECT=1000, SETTLE=4   1: tied 0, EXPECT=0110, SETTLE=4
//   2: tied 0, EXPECT=0000, SETTLE=4     3: OR gate, EXPECT=1110, SETTLE=1
// Expected sweep outcomes are queued at start; the monitor pops on done.
module tb_gate_sweep_controller;

  localparam int         SC  [4] = '{4, 4, 4, 1};
  localparam logic [3:0] EXP [4] = '{4'b1000, 4'b0110, 4'b0000, 4'b1110};

  typedef struct {
    logic [3:0] res;
    logic [3:0] fm;
    logic       pass;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic [3:0] st, ab;
  logic [3:0] busy_w, done_w, pass_w, in0_w, in1_w;
  logic [3:0][1:0] vi_w;
  logic [3:0][3:0] res_w, fm_w;

  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  exp_t exp_q [4][$];
  logic [3:0] pend_pass = '0;
  logic [3:0] pexp = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    gate_sweep_controller_if u_if();
    logic dout, gi0, gi1;
    assign u_if.start = st[g];
    assign u_if.abort = ab[g];
    if (g == 0)      begin : g_and assign dout = gi0 & gi1; end
    else if (g == 3) begin : g_or  assign dout = gi0 | gi1; end
    else             begin : g_z   assign dout = 1'b0;      end
    gate_sweep_controller #(.SETTLE_CYCLES(SC[g]), .EXPECT(EXP[g])) u_dut (
      .clk(clk), .rst_n(rst_n), .ctl(u_if), .dut_out(dout), .in0(gi0), .in1(gi1)
    );
    assign busy_w[g] = u_if.busy;
    assign done_w[g] = u_if.done;
    assign pass_w[g] = u_if.pass;
    assign vi_w[g]   = u_if.vec_idx;
    assign res_w[g]  = u_if.result;
    assign fm_w[g]   = u_if.fail_mask;
    assign in0_w[g]  = gi0;
    assign in1_w[g]  = gi1;
  end

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: pass is registered on leaving DONE, so it is
  // checked one cycle after the done pulse.
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      if (pend_pass[i]) begin
        chk($sformatf("pass%0d", i), 32'(pass_w[i]), 32'(pexp[i]));
        pend_pass[i] = 1'b0;
      end
      if (done_w[i] === 1'b1) begin
        if (exp_q[i].size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_done%0d: done=1 at cycle %0d, expected done=0", i, cyc);
        end else begin
          e = exp_q[i].pop_front();
          chk($sformatf("result%0d", i),    32'(res_w[i]), 32'(e.res));
          chk($sformatf("fail_mask%0d", i), 32'(fm_w[i]),  32'(e.fm));
          chk($sformatf("done_cycle%0d", i), cyc, e.cyc);
          pend_pass[i] = 1'b1;
          pexp[i]      = e.pass;
        end
      end
    end
  end

  // Called on a negedge at cycle N; done expected in cycle N + 4*(S+1)+1.
  task automatic kick(int i, logic [3:0] r, logic [3:0] fm, logic p);
    exp_t e;
    e.res = r; e.fm = fm; e.pass = p;
    e.cyc = cyc + 4 * (SC[i] + 1) + 1;
    exp_q[i].push_back(e);
    st[i] = 1'b1;
    @(negedge clk);
    st[i] = 1'b0;
  endtask

  // Each vector must be presented for exactly per = S+1 cycles (S settle + sample).
  task automatic trace(int i, int per);
    for (int v = 0; v < 4; v++) begin
      logic ok = 1'b1;
      for (int j = 0; j < per; j++) begin
        if (vi_w[i] != 2'(v) || {in0_w[i], in1_w[i]} != 2'(v) || busy_w[i] !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk($sformatf("trace%0d_vec%0d", i, v), 32'(ok), 32'd1);
    end
  endtask

  task automatic drain(int i);
    int n = 0;
    while ((exp_q[i].size() != 0 || pend_pass[i]) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q[i].size() != 0 || pend_pass[i]) begin
      n_chk++;
      n_fail++;
      $display("FAIL timeout%0d: %0d sweeps outstanding, expected 0", i, exp_q[i].size());
    end
  endtask

  task automatic chk_clear(string nm, int i);
    chk({nm, "_ctl"}, {28'd0, busy_w[i], done_w[i], pass_w[i], 1'b0}, 32'd0);
    chk({nm, "_vec"}, {28'd0, vi_w[i], in0_w[i], in1_w[i]}, 32'd0);
    chk({nm, "_res"}, {24'd0, res_w[i], fm_w[i]}, 32'd0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0;
    st = '0;
    ab = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk_clear("reset_a", 0);
    repeat (3) @(negedge clk);
    chk("idle_hold", {31'd0, busy_w[0]}, 32'd0);

    // AND sweep, full vector trace and cycle-21 done
    kick(0, 4'b1000, 4'b0000, 1'b1);
    trace(0, 5);
    drain(0);

    // Constant-0 gate against XOR table, then against all-zero table
    kick(1, 4'b0000, 4'b0110, 1'b0);
    drain(1);
    kick(2, 4'b0000, 4'b0000, 1'b1);
    drain(2);

    // start re-pulsed mid-sweep is ignored; done timing unchanged
    kick(0, 4'b1000, 4'b0000, 1'b1);
    n0 = 0;
    while (vi_w[0] != 2'd1 && n0 < 50) begin @(negedge clk); n0++; end
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    chk("restart_ignored", {30'd0, vi_w[0]}, 32'd1);
    drain(0);

    // start and abort together in IDLE: abort wins
    st[0] = 1'b1; ab[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0; ab[0] = 1'b0;
    chk("start_abort_idle", {31'd0, busy_w[0]}, 32'd0);
    repeat (2) @(negedge clk);
    chk("start_abort_stay", {31'd0, busy_w[0]}, 32'd0);

    // start held: DONE -> one IDLE cycle -> second sweep
    begin
      exp_t e;
      n0 = cyc;
      e.res = 4'b1000; e.fm = 4'b0000; e.pass = 1'b1;
      e.cyc = n0 + 21; exp_q[0].push_back(e);
      e.cyc = n0 + 43; exp_q[0].push_back(e);
      st[0] = 1'b1;
      repeat (22) @(negedge clk);
      chk("b2b_idle_gap", {30'd0, busy_w[0], done_w[0]}, 32'd0);
      @(negedge clk);
      chk("b2b_restart", {31'd0, busy_w[0]}, 32'd1);
      st[0] = 1'b0;
      drain(0);
    end

    // OR gate, one-cycle settle
    kick(3, 4'b1110, 4'b0000, 1'b1);
    trace(3, 2);
    drain(3);

    // abort at vec_idx=2: back to IDLE, partial capture kept, no done
    st[3] = 1'b1;
    @(negedge clk);
    st[3] = 1'b0;
    n0 = 0;
    while (vi_w[3] != 2'd2 && n0 < 50) begin @(negedge clk); n0++; end
    ab[3] = 1'b1;
    @(negedge clk);
    ab[3] = 1'b0;
    chk("abort_ctl", {29'd0, busy_w[3], done_w[3], pass_w[3]}, 32'd0);
    chk("abort_vec", {28'd0, vi_w[3], in0_w[3], in1_w[3]}, 32'd0);
    chk("abort_result", {28'd0, res_w[3]}, 32'h2);
    chk("abort_fail_mask", {28'd0, fm_w[3]}, 32'h0);
    repeat (30) @(negedge clk);
    chk("abort_result_held", {28'd0, res_w[3]}, 32'h2);

    // asynchronous reset in the middle of a sweep
    st[0] = 1'b1;
    @(negedge clk);
    st[0] = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_reset_busy", {31'd0, busy_w[0]}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk_clear("async_rst_a", 0);
    chk_clear("async_rst_d", 3);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("post_reset_idle", {31'd0, busy_w[0]}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1);
  end

endmodule
